wr_req_queue: RTL and testbench
===============================

# wr_req_queue

Write-request queue that sits directly upstream of the register-file write decoder. It accepts register write requests (3-bit register index plus data) through a valid/ready handshake and buffers them in a small FIFO. It presents one request per cycle as a registered decoder select and enable, with the matching write data. It absorbs bursts from the write-back stage and honours a downstream stall.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- WIDTH, 64, write-data width in bits
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present on in_addr/in_data
- in_addr  input  3  destination register index
- in_data  input  WIDTH  write data
- in_ready  output  1  queue can accept a request this cycle
- flush  input  1  synchronous clear of all pending and presented requests
- stall  input  1  downstream cannot consume; hold output stage
- dec_in  output  3  registered register index to the 3-to-8 decoder
- dec_e  output  1  registered decoder enable; high = one write this cycle
- wr_data  output  WIDTH  registered data matching dec_in
- count  output  $clog2(DEPTH)+1  number of entries held in the FIFO (excludes output stage)

## Operation
- Storage: circular buffer of DEPTH entries {addr, data}; write pointer, read pointer, count.
- Push: occurs when in_valid && in_ready at a clock edge. in_ready = (count != DEPTH) && !flush. in_ready is combinational from registered state, not from in_valid.
- Pop: occurs when count != 0 && !stall && !flush.
  - The head entry is loaded into dec_in/wr_data.
  - dec_e is set to 1.
  - The read pointer advances.
- Idle: when !stall && count == 0, dec_e <= 0; dec_in/wr_data hold their last values.
- Stall: dec_e, dec_in and wr_data all hold, including dec_e=1. The downstream writes the same request only once; it qualifies with its own stall. FIFO does not pop.
- Simultaneous push and pop: both occur; count is unchanged; pointers both advance.
- Full: count == DEPTH forces in_ready = 0. A pop in the same cycle does not re-enable in_ready until the next cycle; there is no pass-through.
- Empty: a request pushed into an empty queue is not bypassed; it enters the FIFO first.
- Flush (priority over push, pop and stall):
  - count <= 0 and both pointers <= 0.
  - dec_e <= 0.
  - No push occurs that cycle.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. count disambiguates full from empty.
- Ordering: strict FIFO. No coalescing of writes to the same index.

## Timing
- Reset (reset_n low, asynchronous):
  - dec_e = 0, dec_in = 0, wr_data = 0.
  - count = 0, pointers = 0.
  - in_ready = 1 once reset deasserts.
- Reset asserted mid-operation discards all pending requests immediately, without waiting for a clock edge.
- Latency on an empty queue with no stall:
  - Request pushed at edge N.
  - dec_e = 1 with that request after edge N+1, i.e. 2 cycles from in_valid sampled.
- Throughput: one request per cycle sustained when stall = 0.
- count reflects the effect of the edge just taken.

## Test plan
- Reset then idle:
  - Hold reset_n = 0 mid-cycle -> all outputs 0 immediately.
  - After release -> in_ready = 1 and count = 0; dec_e stays 0 with no input.
- Single request:
  - Push addr = 3'd5, data = 0xA5 at edge 1 -> count = 1 after edge 1.
  - After edge 2 -> dec_in = 5, wr_data = 0xA5, dec_e = 1, count = 0.
  - After edge 3 -> dec_e = 0.
- Fill to full with stall = 1:
  - Push addrs 0,1,2,3 -> count = 4, in_ready = 0.
  - A fifth in_valid with addr 7 is not accepted.
  - Release stall -> dec_in sequence 0,1,2,3 on consecutive cycles, then dec_e = 0.
- Wrap-around with simultaneous push/pop:
  - Stream addrs 0..7 with in_valid = 1 every cycle and stall = 0.
  - count stays 1 from edge 1 through edge 8, the pointers wrap twice, and dec_in runs 0..7 in order with no gaps.
- Stall mid-stream:
  - Stall for 3 cycles while dec_e = 1, dec_in = 2 -> dec_in = 2 and dec_e = 1 held all 3 cycles.
  - After release, the next index appears one cycle later with no duplicate or skipped entry.
- Flush with in_valid high and count = 3 -> next cycle: count = 0, dec_e = 0, and the flush-cycle request is dropped.

Source files
------------

// File: rtl/wr_req_queue.sv
// Write-request queue feeding the register-file write decoder: a small circular
// FIFO of {addr, data} behind a valid/ready port, drained into a registered decoder stage.
module wr_req_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     in_valid_i,
  input  logic [2:0]               in_addr_i,
  input  logic [WIDTH-1:0]         in_data_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  input  logic                     stall_i,
  output logic [2:0]               dec_in_o,
  output logic                     dec_e_o,
  output logic [WIDTH-1:0]         wr_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2:0]       addr_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             dec_e_q, dec_e_d;
  logic [2:0]       dec_in_q, dec_in_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Ready depends only on registered state and flush, never on in_valid,
  // so a pop in a full cycle cannot pass a new request through.
  assign in_ready_o = !full && !flush_i;
  assign push       = in_valid_i && in_ready_o;
  assign pop        = !empty && !stall_i && !flush_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dec_e_d   = dec_e_q;
    dec_in_d  = dec_in_q;
    wr_data_d = wr_data_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dec_e_d  = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
        dec_in_d  = addr_mem_q[rd_ptr_q];
        wr_data_d = data_mem_q[rd_ptr_q];
        dec_e_d   = 1'b1;
      end else if (!stall_i) begin
        dec_e_d = 1'b0;
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage array carries no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= in_addr_i;
      data_mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dec_e_q   <= 1'b0;
      dec_in_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dec_e_q   <= dec_e_d;
      dec_in_q  <= dec_in_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign dec_e_o   = dec_e_q;
  assign dec_in_o  = dec_in_q;
  assign wr_data_o = wr_data_q;
  assign count_o   = count_q;

endmodule

// File: tb/tb_wr_req_queue.sv
// Self-checking bench for wr_req_queue: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the request stream.
module tb_wr_req_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic [2:0]       in_addr;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             stall;
  logic [2:0]       dec_in;
  logic             dec_e;
  logic [WIDTH-1:0] wr_data;
  logic [CW-1:0]    count;

  wr_req_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .in_valid_i (in_valid),
    .in_addr_i  (in_addr),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .flush_i    (flush),
    .stall_i    (stall),
    .dec_in_o   (dec_in),
    .dec_e_o    (dec_e),
    .wr_data_o  (wr_data),
    .count_o    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } req_t;

  // Reference model: pending requests as a queue, plus the presented request.
  req_t             mq[$];
  logic             m_e;
  logic [2:0]       m_addr;
  logic [WIDTH-1:0] m_data;
  logic             exp_ready;
  logic             obs_ready;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    mq.delete();
    m_e    = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // Entered and left at posedge+1: drive inputs, sample in_ready, advance model and DUT one edge.
  task automatic step(input logic v, input logic [2:0] a, input logic [WIDTH-1:0] d,
                      input logic s, input logic f);
    logic do_pop;
    logic accept;
    req_t r;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    stall    = s;
    flush    = f;
    #1;
    obs_ready = in_ready;
    exp_ready = (mq.size() != DEPTH) && !f;
    accept    = v && exp_ready;
    do_pop    = (mq.size() != 0) && !s && !f;
    if (f) begin
      mq.delete();
      m_e = 1'b0;
    end else begin
      if (do_pop) begin
        r      = mq.pop_front();
        m_addr = r.addr;
        m_data = r.data;
        m_e    = 1'b1;
      end else if (!s) begin
        m_e = 1'b0;
      end
      if (accept) begin
        r.addr = a;
        r.data = d;
        mq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 3'd6, 64'h1111, 1'b0, 1'b0);
    step(1'b1, 3'd4, 64'h2222, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({dec_e, dec_in, wr_data, count} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: dec_e=%0b dec_in=%0d wr_data=%h count=%0d, required all 0",
               dec_e, dec_in, wr_data, count);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b count=%0d, required 1 and 0", in_ready, count);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++;
      if (dec_e !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: cycle %0d dec_e=%0b, required 0", i, dec_e);
      end
    end
  endtask

  task automatic test_single();
    step(1'b1, 3'd5, 64'hA5, 1'b0, 1'b0);
    n_checks++;
    if (count !== CW'(1) || dec_e !== 1'b0) begin
      n_fail++;
      $display("FAIL single_push: count=%0d dec_e=%0b, required 1 and 0", count, dec_e);
    end
    idle();
    n_checks++;
    if (dec_e !== 1'b1 || dec_in !== 3'd5 || wr_data !== 64'hA5 || count !== '0) begin
      n_fail++;
      $display("FAIL single_out: dec_e=%0b dec_in=%0d wr_data=%h count=%0d, required 1 5 a5 0",
               dec_e, dec_in, wr_data, count);
    end
    idle();
    n_checks++;
    if (dec_e !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: dec_e=%0b, required 0", dec_e);
    end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'(i), 64'(i * 17), 1'b1, 1'b0);
      n_checks++;
      if (count !== CW'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_count: push %0d count=%0d, required %0d", i, count, i + 1);
      end
    end
    step(1'b1, 3'd7, 64'hDEAD, 1'b1, 1'b0);
    n_checks++;
    if (obs_ready !== 1'b0 || count !== CW'(4)) begin
      n_fail++;
      $display("FAIL full_reject: in_ready=%0b count=%0d, required 0 and 4", obs_ready, count);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      n_checks++;
      if (dec_e !== 1'b1 || dec_in !== 3'(i) || wr_data !== 64'(i * 17) || count !== CW'(3 - i)) begin
        n_fail++;
        $display("FAIL full_drain: step %0d dec_e=%0b dec_in=%0d wr_data=%h count=%0d, required 1 %0d %h %0d",
                 i, dec_e, dec_in, wr_data, count, i, 64'(i * 17), 3 - i);
      end
    end
    idle();
    n_checks++;
    if (dec_e !== 1'b0) begin
      n_fail++;
      $display("FAIL full_after: dec_e=%0b, required 0 (addr 7 must not appear)", dec_e);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 64'(100 + i), 1'b0, 1'b0);
      n_checks++;
      if (count !== CW'(1) || (i > 0 && (dec_e !== 1'b1 || dec_in !== 3'(i - 1)))) begin
        n_fail++;
        $display("FAIL wrap: edge %0d count=%0d dec_e=%0b dec_in=%0d, required 1 1 %0d",
                 i + 1, count, dec_e, dec_in, i - 1);
      end
    end
    idle();
    n_checks++;
    if (dec_e !== 1'b1 || dec_in !== 3'd7 || wr_data !== 64'd107 || count !== '0) begin
      n_fail++;
      $display("FAIL wrap_tail: dec_e=%0b dec_in=%0d wr_data=%0d count=%0d, required 1 7 107 0",
               dec_e, dec_in, wr_data, count);
    end
    idle();
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i), 64'(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'(4 + i), 64'(204 + i), 1'b1, 1'b0);
      n_checks++;
      if (dec_e !== 1'b1 || dec_in !== 3'd2 || wr_data !== 64'd202) begin
        n_fail++;
        $display("FAIL stall_hold: cycle %0d dec_e=%0b dec_in=%0d wr_data=%0d, required 1 2 202",
                 i, dec_e, dec_in, wr_data);
      end
    end
    for (int i = 3; i < 7; i++) begin
      idle();
      n_checks++;
      if (dec_e !== 1'b1 || dec_in !== 3'(i) || wr_data !== 64'(200 + i)) begin
        n_fail++;
        $display("FAIL stall_resume: dec_e=%0b dec_in=%0d wr_data=%0d, required 1 %0d %0d",
                 dec_e, dec_in, wr_data, i, 200 + i);
      end
    end
    idle();
    n_checks++;
    if (dec_e !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL stall_end: dec_e=%0b count=%0d, required 0 0", dec_e, count);
    end
  endtask

  task automatic test_flush();
    step(1'b1, 3'd1, 64'h10, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) step(1'b1, 3'(2 + i), 64'(32 + i), 1'b1, 1'b0);
    n_checks++;
    if (count !== CW'(3) || dec_e !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: count=%0d dec_e=%0b, required 3 1", count, dec_e);
    end
    step(1'b1, 3'd6, 64'h66, 1'b1, 1'b1);
    n_checks++;
    if (count !== '0 || dec_e !== 1'b0 || obs_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: count=%0d dec_e=%0b in_ready=%0b, required 0 0 0", count, dec_e, obs_ready);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      n_checks++;
      if (dec_e !== 1'b0 || count !== '0) begin
        n_fail++;
        $display("FAIL flush_drop: cycle %0d dec_e=%0b count=%0d, required 0 0", i, dec_e, count);
      end
    end
  endtask

  task automatic test_random();
    logic             v, s, f;
    logic [2:0]       a;
    logic [WIDTH-1:0] d;
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      a = 3'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      s = 1'($urandom_range(0, 9) < 3);
      f = 1'($urandom_range(0, 31) == 0);
      step(v, a, d, s, f);
      n_checks++;
      if (obs_ready !== exp_ready || dec_e !== m_e || dec_in !== m_addr || wr_data !== m_data
          || count !== CW'(mq.size())) begin
        n_fail++;
        $display("FAIL random: cycle %0d ready=%0b dec_e=%0b dec_in=%0d wr_data=%h count=%0d, required %0b %0b %0d %h %0d",
                 i, obs_ready, dec_e, dec_in, wr_data, count, exp_ready, m_e, m_addr, m_data, mq.size());
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    flush    = 1'b0;
    stall    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_fill_full();
    test_wrap();
    test_stall();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
